// File: rtl/i2c_pkg.sv
// Shared types and helpers for the I2C master bit engine.
// Abort-on-NACK behaviour is enabled by defining I2C_ACK_ABORT_EN.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    SLADDR,
    ADDR_HI,
    ADDR_LO,
    DATA_WR,
    RESTART,
    SLADDR_RD,
    DATA_RD,
    STOP
  } i2c_state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // Clock cycles per quarter of an SCL period.
  function automatic int calc_div(input int clk_freq, input int i2c_freq);
    return clk_freq / (i2c_freq * 4);
  endfunction

  // States made of nine bit slots (eight data bits plus the ACK slot).
  function automatic logic is_byte_state(input i2c_state_t s);
    return s inside {SLADDR, ADDR_HI, ADDR_LO, DATA_WR, SLADDR_RD, DATA_RD};
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-tick generator: one-cycle pulse every DIV clocks, held cleared while
// the master is idle so every transaction starts from a fresh count.
module i2c_tick_gen #(
  parameter int DIV = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == CW'(DIV - 1)) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/i2c_master_dri.sv
// I2C master executing single-byte register reads/writes for sensor controllers.
// Define I2C_ACK_ABORT_EN to jump to STOP after any NACKed byte.
module i2c_master_dri
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h1E,
  parameter int         CLK_FREQ   = 50_000_000,
  parameter int         I2C_FREQ   = 250_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i2c_exec,
  input  logic        bit_ctrl,
  input  logic        i2c_rh_wl,
  input  logic [15:0] i2c_addr,
  input  logic [7:0]  i2c_data_w,
  output logic [7:0]  i2c_data_r,
  output logic        i2c_done,
  output logic        i2c_ack,
  output logic        scl,
  inout  wire         sda
);

  localparam int DIV = calc_div(CLK_FREQ, I2C_FREQ);

  i2c_state_t r_state;
  i2c_state_t w_next_state;
  logic [7:0] w_next_tx;
  logic [1:0] r_q;
  logic [3:0] r_bit;
  logic [7:0] r_tx;
  logic [7:0] r_rx;
  logic       r_bit_ctrl;
  logic       r_rh_wl;
  logic [15:0] r_addr;
  logic [7:0] r_data_w;
  logic       r_scl;
  logic       r_sda_oe;
  logic       r_done;
  logic       r_ack;
  logic [7:0] r_data_r;
  logic       r_armed;
  logic       w_tick;
  logic       w_sda_in;
  logic       w_byte_state;
  logic       w_ack_slot;
  logic       w_abort;

  i2c_tick_gen #(
    .DIV(DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (r_state == IDLE),
    .o_tick(w_tick)
  );

  assign sda          = r_sda_oe ? 1'b0 : 1'bz;
  assign w_sda_in     = sda;
  assign w_byte_state = is_byte_state(r_state);
  assign w_ack_slot   = w_byte_state && (r_bit == 4'd8) && (r_state != DATA_RD);

  // r_ack is cleared per command, so a set flag in an ACK slot means this slot NACKed.
`ifdef I2C_ACK_ABORT_EN
  assign w_abort = w_ack_slot && r_ack;
`else
  assign w_abort = 1'b0;
`endif

  always_comb begin
    w_next_state = IDLE;
    w_next_tx    = 8'h00;
    case (r_state)
      START: begin
        w_next_state = SLADDR;
        w_next_tx    = {SLAVE_ADDR, 1'b0};
      end
      SLADDR: begin
        w_next_state = r_bit_ctrl ? ADDR_HI : ADDR_LO;
        w_next_tx    = r_bit_ctrl ? r_addr[15:8] : r_addr[7:0];
      end
      ADDR_HI: begin
        w_next_state = ADDR_LO;
        w_next_tx    = r_addr[7:0];
      end
      ADDR_LO: begin
        w_next_state = r_rh_wl ? RESTART : DATA_WR;
        w_next_tx    = r_data_w;
      end
      DATA_WR:   w_next_state = STOP;
      RESTART: begin
        w_next_state = SLADDR_RD;
        w_next_tx    = {SLAVE_ADDR, 1'b1};
      end
      SLADDR_RD: w_next_state = DATA_RD;
      DATA_RD:   w_next_state = STOP;
      default:   w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_q        <= 2'd0;
      r_bit      <= 4'd0;
      r_tx       <= 8'h00;
      r_rx       <= 8'h00;
      r_bit_ctrl <= 1'b0;
      r_rh_wl    <= 1'b0;
      r_addr     <= 16'h0000;
      r_data_w   <= 8'h00;
      r_scl      <= 1'b1;
      r_sda_oe   <= 1'b0;
      r_done     <= 1'b0;
      r_ack      <= ACK;
      r_data_r   <= 8'h00;
      r_armed    <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      r_done  <= 1'b0;
      if (r_state == IDLE) begin
        r_q   <= 2'd0;
        r_bit <= 4'd0;
        // r_armed blocks a strobe coinciding with reset release.
        if (i2c_exec && r_armed) begin
          r_bit_ctrl <= bit_ctrl;
          r_rh_wl    <= i2c_rh_wl;
          r_addr     <= i2c_addr;
          r_data_w   <= i2c_data_w;
          r_ack      <= ACK;
          r_state    <= START;
        end
      end else if (w_tick) begin
        r_q <= r_q + 2'd1;
        case (r_q)
          2'd0: begin
            if (r_state == STOP)
              r_sda_oe <= 1'b1;
            else if (r_state == START || r_state == RESTART)
              r_sda_oe <= 1'b0;
            else if (r_bit == 4'd8 || r_state == DATA_RD)
              r_sda_oe <= 1'b0;
            else
              r_sda_oe <= ~r_tx[3'd7 - r_bit[2:0]];
          end
          2'd1: r_scl <= 1'b1;
          2'd2: begin
            if (r_state == START || r_state == RESTART)
              r_sda_oe <= 1'b1;
            else if (r_state == STOP)
              r_sda_oe <= 1'b0;
            else if (w_ack_slot) begin
              if (w_sda_in == NACK) r_ack <= NACK;
            end else if (r_state == DATA_RD && r_bit != 4'd8)
              r_rx <= {r_rx[6:0], w_sda_in};
          end
          default: begin
            // SCL stays high through STOP so the bus ends idle.
            if (r_state != STOP) r_scl <= 1'b0;
            if (w_byte_state && r_bit != 4'd8) begin
              r_bit <= r_bit + 4'd1;
            end else begin
              r_bit <= 4'd0;
              if (r_state == STOP) begin
                r_state <= IDLE;
                r_done  <= 1'b1;
              end else if (w_abort) begin
                r_state <= STOP;
              end else begin
                r_state <= w_next_state;
                r_tx    <= w_next_tx;
                if (r_state == DATA_RD) r_data_r <= r_rx;
              end
            end
          end
        endcase
      end
    end
  end

  assign scl        = r_scl;
  assign i2c_done   = r_done;
  assign i2c_ack    = r_ack;
  assign i2c_data_r = r_data_r;

endmodule

// File: tb/tb_i2c_master_dri.sv
// Self-checking bench for i2c_master_dri: vector table, bus monitor with
// slave model, and hand-written exec/reset corner sequences.
module tb_i2c_master_dri;

  localparam int DIV  = 50;
  localparam int SLOT = 4 * DIV;
`ifdef I2C_ACK_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif
  localparam int NACK_SLOTS = ABORT ? 11 : 29;

  typedef struct {
    logic        rw;
    logic        bc;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  sdata;
    logic        ack_en;
    logic        exp_ack;
    logic [7:0]  exp_data_r;
    int          exp_slots;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i2c_exec = 1'b0;
  logic        bit_ctrl = 1'b0;
  logic        i2c_rh_wl = 1'b0;
  logic [15:0] i2c_addr = 16'h0000;
  logic [7:0]  i2c_data_w = 8'h00;
  wire  [7:0]  i2c_data_r;
  wire         i2c_done;
  wire         i2c_ack;
  wire         scl;
  wire         sda;

  logic        slave_oe = 1'b0;
  logic        slave_ack_en = 1'b1;
  logic [7:0]  slave_rd_data = 8'h00;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int exp_q[$];
  int obs_q[$];
  vec_t vecs[5];

  pullup (sda);
  assign sda = slave_oe ? 1'b0 : 1'bz;

  i2c_master_dri #(
    .SLAVE_ADDR(7'h1E),
    .CLK_FREQ  (50_000_000),
    .I2C_FREQ  (250_000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i2c_exec  (i2c_exec),
    .bit_ctrl  (bit_ctrl),
    .i2c_rh_wl (i2c_rh_wl),
    .i2c_addr  (i2c_addr),
    .i2c_data_w(i2c_data_w),
    .i2c_data_r(i2c_data_r),
    .i2c_done  (i2c_done),
    .i2c_ack   (i2c_ack),
    .scl       (scl),
    .sda       (sda)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end
  initial forever begin @(negedge clk); if (i2c_done) done_cnt++; end

  // Bus monitor plus slave: logs START(-1)/STOP(-2)/bytes, ACKs written bytes,
  // and returns slave_rd_data after an ACKed read address.
  initial begin
    logic       p_scl, p_sda, cs, cd, rd_active;
    logic [7:0] shreg, last_byte;
    int         bitcnt;
    p_scl = 1'b1; p_sda = 1'b1; rd_active = 1'b0;
    shreg = 8'h00; last_byte = 8'h00; bitcnt = 0;
    forever begin
      @(negedge clk);
      cs = scl;
      cd = sda;
      if (!rst_n) begin
        bitcnt = 0; slave_oe = 1'b0; rd_active = 1'b0; last_byte = 8'h00;
      end else if (p_scl && cs && p_sda && !cd) begin
        obs_q.push_back(-1);
        bitcnt = 0; last_byte = 8'h00; rd_active = 1'b0; slave_oe = 1'b0;
      end else if (p_scl && cs && !p_sda && cd) begin
        obs_q.push_back(-2);
        bitcnt = 0; rd_active = 1'b0; slave_oe = 1'b0;
      end else if (!p_scl && cs) begin
        if (bitcnt < 8) begin
          shreg = {shreg[6:0], cd};
          if (bitcnt == 7) begin
            obs_q.push_back(int'(shreg));
            last_byte = shreg;
          end
        end
        bitcnt = (bitcnt == 8) ? 0 : bitcnt + 1;
      end else if (p_scl && !cs) begin
        if (bitcnt == 8) begin
          slave_oe  = rd_active ? 1'b0 : slave_ack_en;
          rd_active = 1'b0;
        end else if (bitcnt == 0) begin
          slave_oe = 1'b0;
          if (last_byte == 8'h3D && slave_ack_en) begin
            rd_active = 1'b1;
            slave_oe  = ~slave_rd_data[7];
          end
        end else if (rd_active) begin
          slave_oe = ~slave_rd_data[7 - bitcnt];
        end
      end
      p_scl = cs;
      p_sda = cd;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic push_expected(input vec_t v);
    exp_q.push_back(-1);
    exp_q.push_back(8'h3C);
    if (!v.ack_en && ABORT) begin
      exp_q.push_back(-2);
      return;
    end
    if (v.bc) exp_q.push_back(int'(v.addr[15:8]));
    exp_q.push_back(int'(v.addr[7:0]));
    if (v.rw) begin
      exp_q.push_back(-1);
      exp_q.push_back(8'h3D);
      exp_q.push_back(v.ack_en ? int'(v.sdata) : 8'hFF);
    end else begin
      exp_q.push_back(int'(v.wdata));
    end
    exp_q.push_back(-2);
  endtask

  task automatic compare_bus();
    int n;
    repeat (4) @(negedge clk);
    check("bus_event_count", obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check("bus_event", obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic run_txn(input int idx, input vec_t v, input bit mid_exec);
    int  t0, lat, dc0;
    bit  got;
    slave_ack_en  = v.ack_en;
    slave_rd_data = v.sdata;
    bit_ctrl   = v.bc;
    i2c_rh_wl  = v.rw;
    i2c_addr   = v.addr;
    i2c_data_w = v.wdata;
    push_expected(v);
    dc0 = done_cnt;
    @(negedge clk);
    i2c_exec = 1'b1;
    t0 = cyc;
    @(negedge clk);
    i2c_exec   = 1'b0;
    bit_ctrl   = ~v.bc;
    i2c_rh_wl  = ~v.rw;
    i2c_addr   = ~v.addr;
    i2c_data_w = ~v.wdata;
    if (mid_exec) begin
      repeat (1000) @(negedge clk);
      i2c_addr = 16'h0077;
      i2c_exec = 1'b1;
      @(negedge clk);
      i2c_exec = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < (v.exp_slots + 4) * SLOT && !got; i++) begin
      @(negedge clk);
      if (i2c_done) got = 1'b1;
    end
    lat = cyc - t0;
    check("done_seen", int'(got), 1);
    if (got) begin
      check_range("done_latency", lat, v.exp_slots * SLOT - DIV, v.exp_slots * SLOT + DIV);
      check("ack_at_done", int'(i2c_ack), int'(v.exp_ack));
      check("data_r_at_done", int'(i2c_data_r), int'(v.exp_data_r));
      @(negedge clk);
      check("done_width", int'(i2c_done), 0);
      check("data_r_hold", int'(i2c_data_r), int'(v.exp_data_r));
    end
    if (mid_exec) begin
      repeat (2 * SLOT) @(negedge clk);
      check("done_count", done_cnt - dc0, 1);
    end
    $display("txn %0d: rw=%0d bc=%0d addr=%04h wdata=%02h ack=%0d data_r=%02h cycles=%0d",
             idx, v.rw, v.bc, v.addr, v.wdata, i2c_ack, i2c_data_r, lat);
    compare_bus();
  endtask

  initial begin
    vec_t vclean;
    int   dc0;
    vecs[0] = '{1'b0, 1'b0, 16'h0000, 8'h03, 8'h00, 1'b1, 1'b0, 8'h00, 29};
    vecs[1] = '{1'b1, 1'b0, 16'h000E, 8'h00, 8'hA5, 1'b1, 1'b0, 8'hA5, 39};
    vecs[2] = '{1'b0, 1'b1, 16'h1234, 8'h55, 8'h00, 1'b1, 1'b0, 8'hA5, 38};
    vecs[3] = '{1'b1, 1'b1, 16'h0102, 8'h00, 8'h3C, 1'b1, 1'b0, 8'h3C, 48};
    vecs[4] = '{1'b0, 1'b0, 16'h0010, 8'h99, 8'h00, 1'b0, 1'b1, 8'h3C, NACK_SLOTS};

    repeat (5) @(negedge clk);
    check("reset_scl", int'(scl), 1);
    check("reset_sda", int'(sda), 1);
    check("reset_done", int'(i2c_done), 0);
    check("reset_ack", int'(i2c_ack), 0);
    check("reset_data_r", int'(i2c_data_r), 0);

    // Strobe on the reset-release cycle must be ignored.
    rst_n    = 1'b1;
    i2c_exec = 1'b1;
    @(negedge clk);
    i2c_exec = 1'b0;
    repeat (2 * SLOT) @(negedge clk);
    check("exec_at_release_events", obs_q.size(), 0);
    check("exec_at_release_done", done_cnt, 0);
    check("exec_at_release_scl", int'(scl), 1);
    $display("txn -: exec at reset release, bus events=%0d", obs_q.size());
    obs_q.delete();

    for (int i = 0; i < 5; i++) run_txn(i, vecs[i], 1'b0);

    // Busy strobe with another address must not disturb the running write.
    vclean = '{1'b0, 1'b0, 16'h0042, 8'h6B, 8'h00, 1'b1, 1'b0, 8'h3C, 29};
    run_txn(5, vclean, 1'b1);

    // Reset in the middle of ADDR_LO.
    slave_ack_en = 1'b1;
    bit_ctrl = 1'b0; i2c_rh_wl = 1'b0; i2c_addr = 16'h0081; i2c_data_w = 8'h18;
    dc0 = done_cnt;
    @(negedge clk);
    i2c_exec = 1'b1;
    @(negedge clk);
    i2c_exec = 1'b0;
    repeat (12 * SLOT + 2 * DIV) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_scl", int'(scl), 1);
    check("midreset_sda", int'(sda), 1);
    check("midreset_done", int'(i2c_done), 0);
    repeat (2 * SLOT) @(negedge clk);
    check("midreset_no_done", done_cnt - dc0, 0);
    check("midreset_data_r", int'(i2c_data_r), 0);
    $display("txn -: reset during ADDR_LO, scl=%0d sda=%0d", scl, sda);
    obs_q.delete();
    exp_q.delete();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    vclean = '{1'b0, 1'b0, 16'h0000, 8'h03, 8'h00, 1'b1, 1'b0, 8'h00, 29};
    run_txn(6, vclean, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_master_dri.md
# i2c_master_dri

I2C master bit engine that executes single-byte register transactions for the sensor controllers (AP3216C and siblings). It sits directly downstream of a sensor controller. It consumes that controller's exec / read-write / register-address / write-data command, drives SCL/SDA, and returns the read byte plus a one-cycle done pulse. It shares `clk` with the controller, so no synchronisation is needed on the command side.

## Interface
- SLAVE_ADDR, 7'h1E, 7-bit device address (AP3216C).
- CLK_FREQ, 50_000_000, clk frequency in Hz.
- I2C_FREQ, 250_000, SCL frequency in Hz.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i2c_exec  in  1  one-cycle start strobe; sampled only in IDLE.
- bit_ctrl  in  1  1 = 16-bit register address, 0 = 8-bit.
- i2c_rh_wl  in  1  1 = read, 0 = write.
- i2c_addr  in  16  register address; [7:0] only when bit_ctrl=0.
- i2c_data_w  in  8  write byte.
- i2c_data_r  out  8  read byte; valid from i2c_done onward.
- i2c_done  out  1  one-cycle pulse at end of transaction.
- i2c_ack  out  1  0 = all bytes ACKed, 1 = a NACK occurred; valid with i2c_done.
- scl  out  1  I2C clock, push-pull.
- sda  inout  1  I2C data, open-drain: drives 0 or releases to 'z'; external pull-up.

## Operation
- Command latch: on i2c_exec=1 in IDLE, latch bit_ctrl, i2c_rh_wl, i2c_addr and i2c_data_w, clear i2c_ack, and go to START. Strobes while busy are ignored.
- Quarter tick: DIV = CLK_FREQ/(I2C_FREQ*4) clk cycles per tick. Each bit slot is 4 ticks:
  - q0: SCL low, update SDA.
  - q1: SCL rises.
  - q2: sample SDA.
  - q3: SCL falls.
- START: SDA falls while SCL high.
- STOP: SDA rises while SCL high.
- State sequence:
  - IDLE → START → SLADDR (SLAVE_ADDR,0) → [ADDR_HI if bit_ctrl] → ADDR_LO → then:
  - write: DATA_WR → STOP.
  - read: RESTART → SLADDR_RD (SLAVE_ADDR,1) → DATA_RD (master NACK) → STOP.
  - STOP → IDLE.
- Bytes are sent MSB first. The 9th slot of each byte releases SDA and samples ACK. A sampled 1 sets i2c_ack (sticky until the next command).
- DATA_RD shifts 8 sampled bits into a shift register. On the 9th slot the master drives SDA=1 (NACK). i2c_data_r updates at the end of DATA_RD and holds until the next read.
- Reset values: scl=1, sda released, i2c_done=0, i2c_ack=0, i2c_data_r=8'h00, state IDLE, tick counter 0.
- Reset mid-operation: lines return to idle levels immediately and no done pulse is issued. Bus recovery is the controller's responsibility.

## Timing
- Bit slot = 4×DIV clk cycles.
- Write transaction length (START + bytes×9 + STOP):
  - 8-bit address: 1 + 27 + 1 = 29 slots.
  - 16-bit address: 38 slots.
- Read transaction length (START, 18 bits, RESTART, 18 bits, STOP):
  - 8-bit address: 39 slots.
  - 16-bit address: 48 slots.
- i2c_done rises the clk cycle after the last tick of STOP and lasts exactly 1 cycle. A new i2c_exec is accepted on the cycle after i2c_done.
- i2c_exec on the same cycle as reset deassertion is ignored.

## Configuration
- I2C_ACK_ABORT_EN defined: a NACK in any ACK slot jumps to STOP at the next slot. i2c_done comes early with i2c_ack=1.
- I2C_ACK_ABORT_EN undefined: a NACK is only recorded in i2c_ack. The full sequence completes with nominal length.

## Structure
- Package i2c_pkg:
  - state enum (IDLE, START, SLADDR, ADDR_HI, ADDR_LO, DATA_WR, RESTART, SLADDR_RD, DATA_RD, STOP).
  - constant function computing DIV.
  - ACK=0 / NACK=1 constants.
- Sub-module i2c_tick_gen: DIV counter emitting a one-cycle quarter tick, held in reset while the master is IDLE.

## Test plan
- Write 8'h03 to 8'h00 with an ACKing slave model (DIV=50): bus shows bytes 0x3C, 0x00, 0x03 then STOP; i2c_done at 29×200 cycles after exec ±DIV; i2c_ack=0.
- Read 8'h0E with the slave returning 0xA5: bytes 0x3C, 0x0E, repeated START, 0x3D; master NACK on the data byte; i2c_data_r=0xA5; total 39 slots.
- bit_ctrl=1, write 0x55 to 16'h1234: bytes 0x3C, 0x12, 0x34, 0x55; 38 slots.
- Slave never ACKs the address: i2c_ack=1.
  - With I2C_ACK_ABORT_EN: STOP follows the first byte; done at 11 slots.
  - Without it: done at 29 slots.
- i2c_exec pulsed mid-transfer with a different address: ignored; bus bytes unchanged; exactly one i2c_done.
- rst_n asserted during ADDR_LO: scl=1, sda='z', i2c_done=0 within the same cycle. A subsequent exec runs a clean transaction.
